mips_mc_control: RTL
====================

Name: mips_mc_control

Overview:
- Multi-cycle control FSM for the MIPS datapath. It is the driving end of the ALU interface.
- Sequences fetch, decode, execute, memory and writeback for each instruction held in the external IR.
- Generates ALUOP and the operand selects, consumes the ALU equal/notEqual flags to resolve branches, and runs a ready handshake with the unified memory.

Parameters:
- MEM_WAIT_MAX, 255: max cycles to wait for mem_ready in a memory state before trapping to ILLEGAL; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from the cycle after ir_write
- funct  in  6  IR[5:0]
- equal  in  1  ALU flag, In1==In2
- notEqual  in  1  ALU flag, In1!=In2
- mem_ready  in  1  memory completes the current access this cycle
- ALUOP  out  4  ADD 0010, SUB 0110, AND 0000, OR 0001, SLL 1000, SRL 1001, SLT 0111
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=extended imm, 11=sign-ext imm<<2
- ext_zero  out  1  1=zero-extend imm (andi/ori), 0=sign-extend
- pc_write  out  1  PC load strobe
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ir_write  out  1  IR load strobe
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  read request, held until mem_ready
- mem_write  out  1  write request, held until mem_ready
- reg_write  out  1  register file write enable
- reg_dst  out  1  1=rd, 0=rt
- mem_to_reg  out  1  1=MDR, 0=ALUOut
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  high while in ILLEGAL
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - rst_n low forces state=FETCH immediately, including mid-access. All strobes and enables go to 0.
  - While reset is held, all outputs are 0 and ALUOP=0010.
  - The first FETCH strobes appear in the cycle after rst_n rises.
- Unlisted outputs are 0 in each state. Only ir_write, pc_write and instr_done are qualified by inputs; all other outputs are pure functions of state.
- Opcode decode: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, slti=001010, j=000010.
- Funct decode: add=100000, sub=100010, and=100100, or=100101, slt=101010, sll=000000, srl=000010.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut).
  - Next state: R-type with legal funct -> EXEC_R; lw/sw -> MEM_ADDR; beq/bne -> BRANCH; j -> JUMP; addi/andi/ori/slti -> EXEC_I.
  - Any other opcode, or R-type with unknown funct -> ILLEGAL.
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUOP from funct. Go to WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Go to FETCH.
- EXEC_I:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - ALUOP: addi ADD, andi AND, ori OR, slti SLT. ext_zero=1 for andi/ori.
  - Go to WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Go to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: iord=1, mem_read=1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Go to FETCH.
- MEM_WRITE: iord=1, mem_write=1. On mem_ready: instr_done=1, go to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, instr_done=1.
  - pc_write=equal for beq, pc_write=notEqual for bne.
  - Always go to FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. Go to FETCH.
- ILLEGAL: illegal=1, all strobes 0. Absorbing; only reset exits.
- Watchdog:
  - An 8-bit min counter clears on entry to FETCH/MEM_READ/MEM_WRITE and increments each cycle while mem_ready=0.
  - When the count reaches MEM_WAIT_MAX with mem_ready still 0, go to ILLEGAL next edge.
  - mem_ready=1 in that same cycle wins and the access completes.
- Latency with mem_ready tied high: R/I-type 4 cycles, lw 5, sw 4, beq/bne/j 3.

Decomposition:
- mips_ctrl_pkg holds:
  - ALUOP constants;
  - opcode and funct constants;
  - state encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, EXEC_I 10, WB_I 11, ILLEGAL 15;
  - alu_src_b and pc_src select codes.
- Sub-module mips_alu_decode (combinational): opcode and funct -> ALUOP, ext_zero, legal. Used by both the EXEC_R/EXEC_I output logic and the DECODE transition.

Test Plan:
- add (opcode 000000, funct 100000), mem_ready=1 -> state sequence 0,1,6,7,0; ALUOP=0010 in EXEC_R; reg_write=1, reg_dst=1 in WB_R; instr_done high exactly 1 cycle.
- lw with mem_ready low 3 cycles in MEM_READ -> mem_read and iord held 3 cycles; MEM_WB entered on the 4th; mem_to_reg=1; total 8 cycles.
- beq with equal=1, then beq with equal=0, then bne with notEqual=1 -> pc_write=1, 0, 1 respectively in BRANCH; ALUOP=0110; pc_src=01.
- andi (001100) -> ALUOP=0000, ext_zero=1, alu_src_b=10 in EXEC_I; ori -> ALUOP=0001; slti -> ALUOP=0111.
- opcode 111111, then R-type funct 111111 -> ILLEGAL after DECODE; illegal=1, no strobes for 20 cycles; rst_n pulse returns state to FETCH.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in FETCH -> ILLEGAL after 4 wait cycles; rst_n asserted mid MEM_WRITE -> mem_write drops with no clock edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit:
// ALU operation codes, opcode/funct values, state encoding and mux selects.
package mips_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_WB_R      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_I    = 4'd10,
        S_WB_I      = 4'd11,
        S_ILLEGAL   = 4'd15
    } state_e;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that wait on the memory handshake and are watched by the timer.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational instruction decode: opcode/funct to ALU operation,
// immediate extension mode and a legality flag for the DECODE transition.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       ext_zero_o,
    output logic       legal_o
);

    // Map opcode (and funct for R-type) to ALU control.
    always_comb begin
        alu_op_o   = ALU_ADD;
        ext_zero_o = 1'b0;
        legal_o    = 1'b1;
        case (opcode_i)
            OP_R: begin
                case (funct_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    FN_SLL:  alu_op_o = ALU_SLL;
                    FN_SRL:  alu_op_o = ALU_SRL;
                    default: legal_o  = 1'b0;
                endcase
            end
            OP_LW, OP_SW: alu_op_o = ALU_ADD;
            OP_BEQ, OP_BNE: alu_op_o = ALU_SUB;
            OP_J: alu_op_o = ALU_ADD;
            OP_ADDI: alu_op_o = ALU_ADD;
            OP_ANDI: begin
                alu_op_o   = ALU_AND;
                ext_zero_o = 1'b1;
            end
            OP_ORI: begin
                alu_op_o   = ALU_OR;
                ext_zero_o = 1'b1;
            end
            OP_SLTI: alu_op_o = ALU_SLT;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback, drives ALU and datapath selects, and handshakes with memory.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       equal,
    input  logic       notEqual,
    input  logic       mem_ready,
    output logic [3:0] ALUOP,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e     state_q;
    state_e     state_d;
    logic       run_q;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic [3:0] dec_alu_op;
    logic       dec_ext_zero;
    logic       dec_legal;
    logic       timeout;

    mips_alu_decode u_dec (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .alu_op_o   (dec_alu_op),
        .ext_zero_o (dec_ext_zero),
        .legal_o    (dec_legal)
    );

    assign state = state_q;

    // The final wait cycle with no ready traps; ready in that cycle wins.
    assign timeout = (MEM_WAIT_MAX != 0) && run_q && !mem_ready
                     && is_mem_state(state_q) && (wait_q == WAIT_LAST);

    // Wait counter restarts on every entry to a memory state.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || !is_mem_state(state_q)) begin
            wait_d = '0;
        end else if (run_q && !mem_ready && (wait_q != 8'hFF)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // State, run flag and wait counter; run_q holds outputs low until
    // the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            wait_q  <= wait_d;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d    = state_q;
        ALUOP      = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        ext_zero   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_ILLEGAL;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_BROFF;
                    if (!dec_legal) begin
                        state_d = S_ILLEGAL;
                    end else begin
                        case (opcode)
                            OP_R:           state_d = S_EXEC_R;
                            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                            OP_BEQ, OP_BNE: state_d = S_BRANCH;
                            OP_J:           state_d = S_JUMP;
                            default:        state_d = S_EXEC_I;
                        endcase
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    ALUOP     = dec_alu_op;
                    state_d   = S_WB_R;
                end
                S_WB_R: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ALUOP     = dec_alu_op;
                    ext_zero  = dec_ext_zero;
                    state_d   = S_WB_I;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = (opcode == OP_SW) ? S_MEM_WRITE
                                                  : S_MEM_READ;
                end
                S_MEM_READ: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end else if (timeout) begin
                        state_d = S_ILLEGAL;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WRITE: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else if (timeout) begin
                        state_d = S_ILLEGAL;
                    end
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    ALUOP      = ALU_SUB;
                    pc_src     = PC_ALUOUT;
                    pc_write   = (opcode == OP_BEQ) ? equal : notEqual;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JUMP: begin
                    pc_src     = PC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule
